// File: rtl/ahb_master_burst_ctrl_pkg.sv
// Shared AHB types and burst helpers for the master burst sequencer.
package ahb_master_burst_ctrl_pkg;

  typedef enum logic [2:0] {
    BURST_SINGLE = 3'd0,
    BURST_INCR   = 3'd1,
    BURST_WRAP4  = 3'd2,
    BURST_INCR4  = 3'd3,
    BURST_WRAP8  = 3'd4,
    BURST_INCR8  = 3'd5,
    BURST_WRAP16 = 3'd6,
    BURST_INCR16 = 3'd7
  } hburst_type;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_type;

  localparam int unsigned BEAT_CNT_W = 4;

  // Beats minus one; INCR is treated as a single beat.
  function automatic logic [3:0] burst_beat_limit(hburst_type burst);
    logic [3:0] limit;
    case (burst)
      BURST_WRAP4, BURST_INCR4:   limit = 4'd3;
      BURST_WRAP8, BURST_INCR8:   limit = 4'd7;
      BURST_WRAP16, BURST_INCR16: limit = 4'd15;
      default:                    limit = 4'd0;
    endcase
    return limit;
  endfunction

  function automatic logic burst_is_wrap(hburst_type burst);
    return (burst == BURST_WRAP4) || (burst == BURST_WRAP8) || (burst == BURST_WRAP16);
  endfunction

endpackage

// File: rtl/ahb_master_burst_ctrl_addr_gen.sv
// Burst address register and beat counter; wraps inside the burst block for WRAPx.
module ahb_burst_addr_gen
  import ahb_master_burst_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  hclk,
  input  logic                  hreset_n,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic                  advance,
  input  hburst_type            burst,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  first_beat,
  output logic                  last_beat
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;

  logic [BEAT_CNT_W-1:0] count;
  logic [BEAT_CNT_W-1:0] limit;
  logic [ADDR_WIDTH-1:0] incr_addr;
  logic [ADDR_WIDTH-1:0] wrap_mask;
  logic [ADDR_WIDTH-1:0] addr_next;

  // Next beat address: linear step, or low bits modulo the wrap block.
  always_comb begin
    limit     = burst_beat_limit(burst);
    incr_addr = addr + ADDR_WIDTH'(BYTES);
    wrap_mask = ((ADDR_WIDTH'(limit) + ADDR_WIDTH'(1)) * ADDR_WIDTH'(BYTES)) - ADDR_WIDTH'(1);
    addr_next = incr_addr;
    if (burst_is_wrap(burst)) begin
      addr_next = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
    end
  end

  assign first_beat = (count == '0);
  assign last_beat  = (count == limit);

  // Load on command accept; step on each accepted beat except the last, so haddr stays put.
  always_ff @(posedge hclk) begin
    if (!hreset_n) begin
      addr  <= '0;
      count <= '0;
    end else if (load) begin
      addr  <= start_addr;
      count <= '0;
    end else if (advance && !last_beat) begin
      addr  <= addr_next;
      count <= count + BEAT_CNT_W'(1);
    end
  end

endmodule

// File: rtl/ahb_master_burst_ctrl.sv
// Master-side AHB burst sequencer: request/grant handshake, then pipelined NONSEQ/SEQ burst.
module ahb_master_burst_ctrl
  import ahb_master_burst_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SLAVE_NUM  = 2
) (
  input  logic                         hclk,
  input  logic                         hreset_n,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [ADDR_WIDTH-1:0]        cmd_addr,
  input  hburst_type                   cmd_burst,
  input  logic                         cmd_write,
  input  logic [$clog2(SLAVE_NUM)-1:0] cmd_slave,
  input  logic [DATA_WIDTH-1:0]        wdata_in,
  output logic                         wdata_ack,
  output logic [DATA_WIDTH-1:0]        rdata_out,
  output logic                         rdata_valid,
  output logic                         done,
  output logic [SLAVE_NUM-1:0]         hreq,
  input  logic [SLAVE_NUM-1:0]         hgrant,
  input  logic                         hwait,
  output logic [ADDR_WIDTH-1:0]        haddr,
  output htrans_type                   htrans,
  output logic                         hwrite,
  output hburst_type                   hburst,
  output logic [DATA_WIDTH-1:0]        hwdata,
  input  logic [DATA_WIDTH-1:0]        hrdata
);

  localparam int unsigned SLAVE_W = $clog2(SLAVE_NUM);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_REQ       = 2'd1,
    ST_ADDR      = 2'd2,
    ST_LAST_DATA = 2'd3
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [SLAVE_W-1:0]   slave;
  logic [SLAVE_NUM-1:0] hreq_next;
  htrans_type           htrans_next;
  logic                 accept_cmd;
  logic                 beat_accept;
  logic                 first_beat;
  logic                 last_beat;
  logic                 ready_raw;
  logic                 wack_raw;
  logic                 rvalid_raw;
  logic                 done_raw;

  ahb_burst_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_addr_gen (
    .hclk       (hclk),
    .hreset_n   (hreset_n),
    .load       (accept_cmd),
    .start_addr (cmd_addr),
    .advance    (beat_accept),
    .burst      (hburst),
    .addr       (haddr),
    .first_beat (first_beat),
    .last_beat  (last_beat)
  );

  // Next state, next registered bus controls, and per-cycle handshake pulses.
  always_comb begin
    state_next  = state;
    hreq_next   = hreq;
    htrans_next = htrans;
    accept_cmd  = 1'b0;
    beat_accept = 1'b0;
    ready_raw   = 1'b0;
    wack_raw    = 1'b0;
    rvalid_raw  = 1'b0;
    done_raw    = 1'b0;
    case (state)
      ST_IDLE: begin
        ready_raw = 1'b1;
        if (cmd_valid) begin
          accept_cmd  = 1'b1;
          state_next  = ST_REQ;
          hreq_next   = SLAVE_NUM'(1) << cmd_slave;
          htrans_next = HTRANS_IDLE;
        end
      end
      ST_REQ: begin
        if (hgrant[slave]) begin
          state_next  = ST_ADDR;
          htrans_next = HTRANS_NONSEQ;
        end
      end
      ST_ADDR: begin
        // Beat k address phase overlaps beat k-1 data phase; hwait stalls both.
        if (!hwait) begin
          beat_accept = 1'b1;
          wack_raw    = hwrite;
          rvalid_raw  = !hwrite && !first_beat;
          if (last_beat) begin
            state_next  = ST_LAST_DATA;
            hreq_next   = '0;
            htrans_next = HTRANS_IDLE;
          end else begin
            htrans_next = HTRANS_SEQ;
          end
        end
      end
      ST_LAST_DATA: begin
        if (!hwait) begin
          rvalid_raw = !hwrite;
          done_raw   = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State and bus-control registers; command fields latched on handshake.
  always_ff @(posedge hclk) begin
    if (!hreset_n) begin
      state  <= ST_IDLE;
      hreq   <= '0;
      htrans <= HTRANS_IDLE;
      hwrite <= 1'b0;
      hburst <= BURST_SINGLE;
      hwdata <= '0;
      slave  <= '0;
    end else begin
      state  <= state_next;
      hreq   <= hreq_next;
      htrans <= htrans_next;
      if (accept_cmd) begin
        hwrite <= cmd_write;
        hburst <= cmd_burst;
        slave  <= cmd_slave;
      end
      if (beat_accept && hwrite) begin
        hwdata <= wdata_in;
      end
    end
  end

  assign cmd_ready   = ready_raw & hreset_n;
  assign wdata_ack   = wack_raw & hreset_n;
  assign rdata_valid = rvalid_raw & hreset_n;
  assign done        = done_raw & hreset_n;
  assign rdata_out   = rdata_valid ? hrdata : '0;

endmodule

// File: doc/ahb_master_burst_ctrl.md
# ahb_master_burst_ctrl

Master-side AHB burst sequencer: the requesting end of the per-slave arbitration handshake. It accepts one burst command from local logic and raises `hreq` toward the selected slave's arbiter. After `hgrant` it drives a pipelined NONSEQ/SEQ address/data burst, honouring `hwait` stalls, then drops the request. One instance per master, sitting between master core logic and the AHB interconnect.

## Interface
- ADDR_WIDTH, 32, haddr/cmd_addr width
- DATA_WIDTH, 32, hwdata/hrdata width; transfer size fixed at DATA_WIDTH/8 bytes
- SLAVE_NUM, 2, number of slave arbiters reachable (>=2)
- hclk  in  1  clock, all logic on rising edge
- hreset_n  in  1  one clock; reset is synchronous and active-low
- cmd_valid  in  1  burst command offered
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_addr  in  ADDR_WIDTH  start address (word aligned)
- cmd_burst  in  hburst_type  burst type
- cmd_write  in  1  1 = write
- cmd_slave  in  $clog2(SLAVE_NUM)  target slave index
- wdata_in  in  DATA_WIDTH  next write beat from core
- wdata_ack  out  1  pulse: wdata_in consumed this cycle
- rdata_out  out  DATA_WIDTH  read beat
- rdata_valid  out  1  pulse: rdata_out valid
- done  out  1  pulse: burst fully complete
- hreq  out  SLAVE_NUM  request, one-hot on cmd_slave
- hgrant  in  SLAVE_NUM  grant from slave arbiters (already gated by ~hwait)
- hwait  in  1  slave wait; stalls current address and data phase
- haddr  out  ADDR_WIDTH, htrans  out  htrans_type, hwrite  out  1, hburst  out  hburst_type, hwdata  out  DATA_WIDTH, hrdata  in  DATA_WIDTH

## Operation
- Beat limit L (beats-1): SINGLE/INCR→0, WRAP4/INCR4→3, WRAP8/INCR8→7, WRAP16/INCR16→15. INCR is a single beat, matching the arbiter monitor.
- States: IDLE, REQ, ADDR, LAST_DATA.
- IDLE: cmd_ready=1, htrans=IDLE, hreq=0. Handshake latches addr/burst/write/slave and goes to REQ.
- REQ: hreq[slave]=1, htrans=IDLE. hgrant[slave]=1 → ADDR with beat 0.
- ADDR: htrans=NONSEQ for beat 0, SEQ afterwards. haddr/hwrite/hburst are held stable while hwait=1. Beat accepted when hwait=0: count++, address advances, wdata_ack=1 (write). On acceptance of beat L → LAST_DATA. hreq stays high through ADDR. hgrant is ignored after beat 0; only hwait stalls.
- LAST_DATA: hreq=0, htrans=IDLE, data phase of beat L. When hwait=0: rdata_valid (read), done=1, → IDLE.
- Address step: INCRx/SINGLE → addr+DATA_WIDTH/8. WRAPx → wrap inside a block of (L+1)·DATA_WIDTH/8 bytes: upper bits kept, low bits incremented modulo block.
- Data phase: hwdata is registered from wdata_in on address acceptance. A read data phase completes on any cycle with hwait=0 and a pending data phase → rdata_out=hrdata, rdata_valid=1.
- Reset (synchronous, any state, mid-burst included): state IDLE, count 0, hreq 0, htrans IDLE, haddr 0, hwrite 0, hburst SINGLE, hwdata 0, wdata_ack/rdata_valid/done 0, rdata_out 0. cmd_ready=0 while hreset_n=0.

## Timing
- Command accept to hreq high: 1 cycle.
- hgrant high in REQ to first NONSEQ on bus: 1 cycle.
- Zero-wait N-beat burst: N address cycles plus 1 LAST_DATA cycle; done on the final data cycle.
- Back-to-back: cmd_ready returns the cycle after done. There is no overlap between bursts.
- hwait during ADDR freezes both the address and the pending data phase. No beat is ever skipped or duplicated.
- Simultaneous hwait=0 and count==L in ADDR: beat L is accepted and LAST_DATA is entered next cycle.

## Structure
- AHB_package: add `htrans_type` (IDLE, BUSY, NONSEQ, SEQ) and a `burst_beat_limit(hburst_type)` function returning 4 bits. Reuse the existing `hburst_type`.
- Sub-module `ahb_burst_addr_gen`: holds the address register and beat counter. Loads on command accept and advances on beat accept. Outputs haddr and last_beat.

## Test plan
- SINGLE write to 0x100, slave 1, grant after 2 cycles, hwait=0 → one NONSEQ at 0x100, hreq[1] drops in LAST_DATA, done 1 cycle later.
- INCR4 read from 0x200 → haddr 0x200,0x204,0x208,0x20C; 4 rdata_valid pulses; done at last.
- WRAP8 write from 0x3F8 → 0x3F8,0x3FC,0x3E0,0x3E4,…,0x3F4; exactly 8 wdata_ack pulses.
- INCR16 read with hwait=1 on beats 3 and 9 (2 cycles each) → haddr held, 16 beats, no duplicated rdata_valid, done after 16+1+4 cycles.
- Synchronous reset asserted in ADDR beat 5 of INCR8 → next edge all outputs at reset values, IDLE, hreq=0; a new command after release runs normally.
